// File: rtl/nexys_starship_score.sv
// Survival-time score counter: counts whole seconds of play in packed BCD,
// freezes at game over and tracks the best completed score since reset.
module nexys_starship_score #(
    parameter int TICK_DIV = 100000000,
    parameter int TICK_W   = 27
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        play_flag,
    input  logic        gameover_ctrl,
    output logic [15:0] score_bcd,
    output logic [15:0] hi_score_bcd,
    output logic        new_hi,
    output logic        sec_tick,
    output logic        q_Sc_Idle,
    output logic        q_Sc_Run,
    output logic        q_Sc_Done
);

    // One-hot encoding lets the LED flags come straight from the state flops.
    typedef enum logic [2:0] {
        SC_IDLE = 3'b001,
        SC_RUN  = 3'b010,
        SC_DONE = 3'b100
    } sc_state_t;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [15:0]       SCORE_MAX = 16'h9999;

    sc_state_t         state_q, state_d;
    logic [TICK_W-1:0] presc_q, presc_d;
    logic [15:0]       score_q, score_d;
    logic [15:0]       hi_q, hi_d;
    logic              new_hi_q, new_hi_d;
    logic              tick_q, tick_d;

    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (v[i*4 +: 4] == 4'd9) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q  <= SC_IDLE;
            presc_q  <= '0;
            score_q  <= '0;
            hi_q     <= '0;
            new_hi_q <= 1'b0;
            tick_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            score_q  <= score_d;
            hi_q     <= hi_d;
            new_hi_q <= new_hi_d;
            tick_q   <= tick_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        presc_d  = presc_q;
        score_d  = score_q;
        hi_d     = hi_q;
        new_hi_d = new_hi_q;
        tick_d   = 1'b0;

        unique case (state_q)
            SC_IDLE: begin
                presc_d  = '0;
                score_d  = '0;
                new_hi_d = 1'b0;
                if (play_flag && !gameover_ctrl) begin
                    state_d = SC_RUN;
                end
            end

            SC_RUN: begin
                // Game over wins over a tick due in the same cycle.
                if (gameover_ctrl) begin
                    state_d = SC_DONE;
                    presc_d = '0;
                    if (score_q > hi_q) begin
                        hi_d     = score_q;
                        new_hi_d = 1'b1;
                    end else begin
                        new_hi_d = 1'b0;
                    end
                end else if (!play_flag) begin
                    state_d  = SC_IDLE;
                    presc_d  = '0;
                    score_d  = '0;
                    new_hi_d = 1'b0;
                end else if (presc_q == TICK_LAST) begin
                    presc_d = '0;
                    tick_d  = 1'b1;
                    if (score_q != SCORE_MAX) begin
                        score_d = bcd_inc(score_q);
                    end
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end

            SC_DONE: begin
                // Always pass through IDLE, even if play is requested again.
                if (!gameover_ctrl) begin
                    state_d  = SC_IDLE;
                    score_d  = '0;
                    new_hi_d = 1'b0;
                end
            end

            default: begin
                state_d = SC_IDLE;
            end
        endcase
    end

    assign score_bcd    = score_q;
    assign hi_score_bcd = hi_q;
    assign new_hi       = new_hi_q;
    assign sec_tick     = tick_q;
    assign q_Sc_Idle    = state_q[0];
    assign q_Sc_Run     = state_q[1];
    assign q_Sc_Done    = state_q[2];

endmodule

// File: tb/tb_nexys_starship_score.sv
// Directed bench for the starship score counter, run with a 4-cycle tick.
module tb_nexys_starship_score;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        play_flag;
    logic        gameover_ctrl;
    logic [15:0] score_bcd;
    logic [15:0] hi_score_bcd;
    logic        new_hi;
    logic        sec_tick;
    logic        q_Sc_Idle;
    logic        q_Sc_Run;
    logic        q_Sc_Done;

    int total = 0;
    int bad   = 0;

    nexys_starship_score #(
        .TICK_DIV(4),
        .TICK_W  (3)
    ) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .play_flag    (play_flag),
        .gameover_ctrl(gameover_ctrl),
        .score_bcd    (score_bcd),
        .hi_score_bcd (hi_score_bcd),
        .new_hi       (new_hi),
        .sec_tick     (sec_tick),
        .q_Sc_Idle    (q_Sc_Idle),
        .q_Sc_Run     (q_Sc_Run),
        .q_Sc_Done    (q_Sc_Done)
    );

    always #5 Clk = ~Clk;

    task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic stepClk(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic play, input logic go);
        play_flag     = play;
        gameover_ctrl = go;
    endtask

    function automatic logic [15:0] toBcd(input int n);
        return {4'((n / 1000) % 10), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
    endfunction

    initial begin
        Reset = 1'b0;
        applyStimulus(1'b0, 1'b0);
        stepClk(3);
        Reset = 1'b1;
        stepClk(1);
        checkOutput("rst_idle", 16'(q_Sc_Idle), 16'd1);
        checkOutput("rst_run", 16'(q_Sc_Run), 16'd0);
        checkOutput("rst_done", 16'(q_Sc_Done), 16'd0);
        checkOutput("rst_score", score_bcd, 16'h0000);
        checkOutput("rst_hi", hi_score_bcd, 16'h0000);
        checkOutput("rst_tick", 16'(sec_tick), 16'd0);
        checkOutput("rst_newhi", 16'(new_hi), 16'd0);

        // Game 1: ten ticks, carry from 0009 to 0010.
        applyStimulus(1'b1, 1'b0);
        stepClk(1);
        checkOutput("g1_enter_run", 16'(q_Sc_Run), 16'd1);
        for (int k = 1; k <= 10; k++) begin
            stepClk(3);
            checkOutput("g1_no_tick", 16'(sec_tick), 16'd0);
            stepClk(1);
            checkOutput("g1_tick", 16'(sec_tick), 16'd1);
            checkOutput("g1_score", score_bcd, toBcd(k));
        end
        checkOutput("g1_score10", score_bcd, 16'h0010);

        // Game over on the exact cycle the eleventh tick is due.
        stepClk(3);
        applyStimulus(1'b1, 1'b1);
        stepClk(1);
        checkOutput("g1_go_tick", 16'(sec_tick), 16'd0);
        checkOutput("g1_go_score", score_bcd, 16'h0010);
        checkOutput("g1_done", 16'(q_Sc_Done), 16'd1);
        checkOutput("g1_hi", hi_score_bcd, 16'h0010);
        checkOutput("g1_newhi", 16'(new_hi), 16'd1);
        stepClk(2);
        checkOutput("g1_frozen", score_bcd, 16'h0010);

        applyStimulus(1'b0, 1'b0);
        stepClk(1);
        checkOutput("g1_idle", 16'(q_Sc_Idle), 16'd1);
        checkOutput("g1_idle_score", score_bcd, 16'h0000);
        checkOutput("g1_idle_newhi", 16'(new_hi), 16'd0);

        // IDLE holds while game over is still asserted.
        applyStimulus(1'b1, 1'b1);
        stepClk(2);
        checkOutput("idle_hold", 16'(q_Sc_Idle), 16'd1);

        // Game 2: lower score, high score kept.
        applyStimulus(1'b1, 1'b0);
        stepClk(1);
        checkOutput("g2_run", 16'(q_Sc_Run), 16'd1);
        stepClk(12);
        checkOutput("g2_score", score_bcd, 16'h0003);
        applyStimulus(1'b1, 1'b1);
        stepClk(1);
        checkOutput("g2_done", 16'(q_Sc_Done), 16'd1);
        checkOutput("g2_hi", hi_score_bcd, 16'h0010);
        checkOutput("g2_newhi", 16'(new_hi), 16'd0);

        // Play held high out of DONE still passes through IDLE.
        applyStimulus(1'b1, 1'b0);
        stepClk(1);
        checkOutput("g2_via_idle", 16'(q_Sc_Idle), 16'd1);
        checkOutput("g2_idle_score", score_bcd, 16'h0000);
        stepClk(1);
        checkOutput("g3_run", 16'(q_Sc_Run), 16'd1);

        // Abort mid-game.
        stepClk(4);
        checkOutput("g3_score", score_bcd, 16'h0001);
        applyStimulus(1'b0, 1'b0);
        stepClk(1);
        checkOutput("abort_idle", 16'(q_Sc_Idle), 16'd1);
        checkOutput("abort_score", score_bcd, 16'h0000);
        checkOutput("abort_hi", hi_score_bcd, 16'h0010);
        checkOutput("abort_newhi", 16'(new_hi), 16'd0);

        // Long game up to saturation.
        applyStimulus(1'b1, 1'b0);
        stepClk(1);
        stepClk(9998 * 4);
        checkOutput("sat_9998", score_bcd, 16'h9998);
        for (int k = 0; k < 3; k++) begin
            stepClk(3);
            checkOutput("sat_no_tick", 16'(sec_tick), 16'd0);
            stepClk(1);
            checkOutput("sat_tick", 16'(sec_tick), 16'd1);
            checkOutput("sat_score", score_bcd, 16'h9999);
        end
        applyStimulus(1'b1, 1'b1);
        stepClk(1);
        checkOutput("sat_hi", hi_score_bcd, 16'h9999);
        checkOutput("sat_newhi", 16'(new_hi), 16'd1);

        // Asynchronous reset in the middle of a game.
        applyStimulus(1'b0, 1'b0);
        stepClk(1);
        applyStimulus(1'b1, 1'b0);
        stepClk(6);
        checkOutput("ar_pre_run", 16'(q_Sc_Run), 16'd1);
        #2;
        Reset = 1'b0;
        #1;
        checkOutput("ar_idle", 16'(q_Sc_Idle), 16'd1);
        checkOutput("ar_run", 16'(q_Sc_Run), 16'd0);
        checkOutput("ar_score", score_bcd, 16'h0000);
        checkOutput("ar_hi", hi_score_bcd, 16'h0000);
        checkOutput("ar_newhi", 16'(new_hi), 16'd0);
        checkOutput("ar_tick", 16'(sec_tick), 16'd0);
        stepClk(1);
        Reset = 1'b1;
        stepClk(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nexys_starship_score.md
Name: nexys_starship_score

Overview:
- Survival-time score counter for the starship game; sits downstream of the game state machine and upstream of the SSD scan/hex-decode mux in the top level.
- Consumes `play_flag` and `gameover_ctrl`, and counts whole seconds of play in 4-digit packed BCD.
- Freezes the count at game over and keeps a high score until reset.
- Drives `score_bcd` / `hi_score_bcd` straight into the SSD digit slots, plus state flags for LEDs.

Parameters:
- TICK_DIV, 100000000, sys_clk cycles per score increment (1 s at 100 MHz); legal range 2..2^27-1; benches use 4.
- TICK_W, 27, prescaler width; must satisfy 2^TICK_W > TICK_DIV-1.

Ports:
- Clk  input  1  system clock (sys_clk, 100 MHz).
- Reset  input  1  asynchronous, active-low reset (asserted at 0).
- play_flag  input  1  level, high while the game SM is in Play.
- gameover_ctrl  input  1  level, high when any monster SM or the game SM signals game over.
- score_bcd  output  16  current score, packed BCD, digit3..digit0 = [15:12]..[3:0].
- hi_score_bcd  output  16  best completed score since reset, packed BCD.
- new_hi  output  1  high in DONE when the last game set a new high score.
- sec_tick  output  1  one-cycle pulse on each score increment.
- q_Sc_Idle, q_Sc_Run, q_Sc_Done  output  1 each  one-hot state flags.

Behaviour:
- Reset (Reset=0, asynchronous) values:
  - state=IDLE, so q_Sc_Idle=1 and the other two state flags are 0.
  - score_bcd=0, hi_score_bcd=0, new_hi=0, sec_tick=0, prescaler=0.
- All other updates happen on posedge Clk. All outputs are registered.
- IDLE:
  - score_bcd and prescaler are held at 0; new_hi=0.
  - If play_flag=1 and gameover_ctrl=0, go to RUN next cycle.
  - If play_flag=1 and gameover_ctrl=1, stay in IDLE.
- RUN:
  - Prescaler counts 0..TICK_DIV-1 and wraps to 0.
  - In the cycle it wraps, sec_tick=1 and score_bcd increments by 1 in BCD: a digit at 9 goes to 0 and carries.
  - Score saturates at 9999. At 9999 sec_tick still pulses but the score holds.
  - First increment occurs TICK_DIV cycles after entering RUN.
- RUN exits, in priority order:
  1. gameover_ctrl=1 → DONE. This beats a same-cycle tick: no increment and no sec_tick in that cycle. Prescaler is cleared.
  2. play_flag=0 with gameover_ctrl=0 is an abort → IDLE. No high-score update.
- High-score update, on the RUN→DONE transition:
  - If score_bcd > hi_score_bcd, then hi_score_bcd ← score_bcd and new_hi ← 1.
  - The comparison is a 16-bit unsigned compare, which is valid for packed BCD.
  - Equal scores do not set new_hi.
- DONE:
  - score_bcd is frozen and sec_tick=0.
  - When play_flag=0 and gameover_ctrl=0, go to IDLE. This clears score_bcd and new_hi on entry to IDLE.
  - If play_flag returns to 1 directly from DONE (gameover_ctrl=0), go to IDLE first; RUN is entered only on a later cycle.
- Reset mid-operation (any state): immediate return to the reset values above; hi_score_bcd is cleared.
- hi_score_bcd is cleared only by reset.

Test Plan (TICK_DIV=4):
- Reset=0 for 3 cycles, then Reset=1 → q_Sc_Idle=1, score_bcd=16'h0000, hi_score_bcd=16'h0000, sec_tick=0.
- play_flag=1 for 40 cycles → first sec_tick 4 cycles after entering RUN; after 10 ticks score_bcd=16'h0010 (BCD carry from 0009).
- In RUN, assert gameover_ctrl on the exact cycle a tick is due → no increment, no sec_tick. Next cycle q_Sc_Done=1, hi_score_bcd=score_bcd, new_hi=1.
- Play a second game to a lower score (e.g. 0003 against a hi of 0010), then game over → hi_score_bcd stays 16'h0010, new_hi=0. Drop both inputs → IDLE, score_bcd=0.
- Force score to 16'h9998 and run 3 ticks → score_bcd=16'h9999 held, sec_tick still pulses.
- Drop play_flag in RUN with gameover_ctrl=0 → IDLE, hi unchanged. Separately, pulse Reset=0 asynchronously mid-RUN → all outputs reset in the same cycle, without waiting for a clock edge.
